// File: rtl/cp0_pkg.sv
// CP0 register numbers, SR/Cause field positions and ExcCode values shared by the
// exception unit and its priority encoder.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    localparam int SR_IE_BIT      = 0;
    localparam int SR_EXL_BIT     = 1;
    localparam int SR_IM_LSB      = 10;
    localparam int CAUSE_BD_BIT   = 31;
    localparam int CAUSE_IP_LSB   = 10;
    localparam int CAUSE_CODE_LSB = 2;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception selector: lowest asserted request index wins, its ExcCode is output.
// Purely combinational, no handshake.
module exc_prio_enc
    import cp0_pkg::*;
#(
    parameter int                 N_EXC     = 5,
    parameter logic [5*N_EXC-1:0] EXC_CODES = {EXC_ADEL, EXC_ADES, EXC_OV, EXC_RI, EXC_ADEL}
) (
    input  logic [N_EXC-1:0] i_req,
    output logic             o_vld,
    output logic [4:0]       o_code
);

    assign o_vld = |i_req;

    // Scan from the lowest-priority end so the last hit is the winning index.
    always_comb begin
        o_code = '0;
        for (int i = N_EXC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_code = EXC_CODES[5*i +: 5];
            end
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId, exception/interrupt arbitration, ERET, in the M stage.
// Flush and redirect are combinational in the take/eret cycle; state commits on the next edge.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int                 N_HWINT    = 6,
    parameter int                 N_EXC      = 5,
    parameter logic [5*N_EXC-1:0] EXC_CODES  = {EXC_ADEL, EXC_ADES, EXC_OV, EXC_RI, EXC_ADEL},
    parameter logic [31:0]        EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0]        PRID       = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc_m,
    input  logic               pc_valid,
    input  logic               bd_m,
    input  logic [N_EXC-1:0]   exc_req,
    input  logic [N_HWINT-1:0] hw_int,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    input  logic               eret,
    output logic [31:0]        cp0_rdata,
    output logic               flush,
    output logic [31:0]        redirect_pc,
    output logic               exl,
    output logic [31:0]        epc_out
);

    logic [N_HWINT-1:0] r_sr_im;
    logic               r_sr_exl;
    logic               r_sr_ie;
    logic [N_HWINT-1:0] r_cause_ip;
    logic [4:0]         r_cause_code;
    logic               r_cause_bd;
    logic [31:0]        r_epc;

    logic        w_exc_vld;
    logic [4:0]  w_exc_code;
    logic        w_int_take;
    logic        w_exc_take;
    logic        w_take;
    logic        w_eret_do;
    logic [31:0] w_take_pc;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    exc_prio_enc #(
        .N_EXC     (N_EXC),
        .EXC_CODES (EXC_CODES)
    ) u_prio (
        .i_req  (exc_req),
        .o_vld  (w_exc_vld),
        .o_code (w_exc_code)
    );

    // Interrupts look at the registered IP copy, so a new line costs one cycle.
    assign w_int_take = pc_valid & r_sr_ie & ~r_sr_exl & |(r_cause_ip & r_sr_im);
    assign w_exc_take = pc_valid & ~r_sr_exl & w_exc_vld;
    assign w_take     = w_int_take | w_exc_take;
    assign w_eret_do  = eret & ~w_take;
    assign w_take_pc  = bd_m ? (pc_m - 32'd4) : pc_m;

    assign flush       = w_take | w_eret_do;
    assign redirect_pc = w_take ? EXC_VECTOR : (w_eret_do ? r_epc : 32'h0);
    assign exl         = r_sr_exl;
    assign epc_out     = r_epc;

    always_comb begin
        w_sr                           = '0;
        w_sr[SR_IM_LSB +: N_HWINT]     = r_sr_im;
        w_sr[SR_EXL_BIT]               = r_sr_exl;
        w_sr[SR_IE_BIT]                = r_sr_ie;
        w_cause                        = '0;
        w_cause[CAUSE_BD_BIT]          = r_cause_bd;
        w_cause[CAUSE_IP_LSB +: N_HWINT] = r_cause_ip;
        w_cause[CAUSE_CODE_LSB +: 5]   = r_cause_code;
    end

    always_comb begin
        case (cp0_addr)
            CP0_REG_SR:    cp0_rdata = w_sr;
            CP0_REG_CAUSE: cp0_rdata = w_cause;
            CP0_REG_EPC:   cp0_rdata = r_epc;
            CP0_REG_PRID:  cp0_rdata = PRID;
            default:       cp0_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im      <= '0;
            r_sr_exl     <= 1'b0;
            r_sr_ie      <= 1'b0;
            r_cause_ip   <= '0;
            r_cause_code <= '0;
            r_cause_bd   <= 1'b0;
            r_epc        <= '0;
        end else begin
            r_cause_ip <= hw_int;
            if (w_take) begin
                r_sr_exl     <= 1'b1;
                r_cause_code <= w_int_take ? EXC_INT : w_exc_code;
                r_cause_bd   <= bd_m;
                r_epc        <= word_align(w_take_pc);
            end else begin
                if (cp0_we && cp0_addr == CP0_REG_SR) begin
                    r_sr_im  <= cp0_wdata[SR_IM_LSB +: N_HWINT];
                    r_sr_exl <= cp0_wdata[SR_EXL_BIT];
                    r_sr_ie  <= cp0_wdata[SR_IE_BIT];
                end
                if (cp0_we && cp0_addr == CP0_REG_EPC) begin
                    r_epc <= word_align(cp0_wdata);
                end
                // ERET's EXL clear overrides an EXL value written by mtc0 SR in the same cycle.
                if (w_eret_do) begin
                    r_sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed scenarios plus randomized traffic against a behavioural CP0 model.
module tb_cp0_exc_unit;

    localparam logic [31:0] VEC    = 32'h0000_4180;
    localparam logic [31:0] PRID_V = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_m;
    logic        pc_valid;
    logic        bd_m;
    logic [4:0]  exc_req;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        exl;
    logic [31:0] epc_out;

    int checks = 0;
    int errors = 0;

    // Architectural model state
    bit        m_ie, m_exl, m_bd;
    bit [5:0]  m_im, m_ip;
    bit [4:0]  m_code;
    bit [31:0] m_epc;
    int        code_tab [5] = '{4, 10, 12, 5, 4};

    cp0_exc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_m        (pc_m),
        .pc_valid    (pc_valid),
        .bd_m        (bd_m),
        .exc_req     (exc_req),
        .hw_int      (hw_int),
        .cp0_we      (cp0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .eret        (eret),
        .cp0_rdata   (cp0_rdata),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .exl         (exl),
        .epc_out     (epc_out)
    );

    always #5 clk = ~clk;

    function automatic bit p_int();
        return pc_valid && m_ie && !m_exl && ((m_ip & m_im) != 6'd0);
    endfunction

    function automatic bit p_exc();
        return pc_valid && !m_exl && (exc_req != 5'd0);
    endfunction

    function automatic bit p_take();
        return p_int() || p_exc();
    endfunction

    function automatic int first_req();
        for (int i = 0; i < 5; i++) if (exc_req[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] p_redirect();
        if (p_take()) return VEC;
        if (eret) return m_epc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            5'd12: begin r[15:10] = m_im; r[1] = m_exl; r[0] = m_ie; end
            5'd13: begin r[31] = m_bd; r[15:10] = m_ip; r[6:2] = m_code; end
            5'd14: r = m_epc;
            5'd15: r = PRID_V;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_commit();
        bit tk, in_int;
        int idx;
        tk     = p_take();
        in_int = p_int();
        idx    = first_req();
        if (reset) begin
            m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_ip = 0; m_code = 0; m_epc = 0;
        end else begin
            if (tk) begin
                m_exl  = 1;
                m_code = in_int ? 5'd0 : 5'(code_tab[idx]);
                m_bd   = bd_m;
                m_epc  = (bd_m ? pc_m - 32'd4 : pc_m) & 32'hFFFF_FFFC;
            end else begin
                if (cp0_we && cp0_addr == 5'd12) begin
                    m_im  = cp0_wdata[15:10];
                    m_exl = cp0_wdata[1];
                    m_ie  = cp0_wdata[0];
                end
                if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata & 32'hFFFF_FFFC;
                if (eret) m_exl = 0;
            end
            m_ip = hw_int;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_commit();
    endtask

    task automatic idle();
        pc_valid = 0; pc_m = 0; bd_m = 0; exc_req = 0;
        cp0_we = 0; cp0_addr = 0; cp0_wdata = 0; eret = 0;
    endtask

    task automatic test_reset();
        logic [4:0]  a;
        logic [31:0] exp;
        reset = 1; hw_int = 0; idle();
        tick(); tick();
        reset = 0;
        for (int k = 12; k <= 15; k++) begin
            a = 5'(k);
            cp0_addr = a;
            exp = (k == 15) ? PRID_V : 32'h0;
            #1;
            checks++;
            if (cp0_rdata !== exp) begin
                errors++;
                $display("FAIL reset_read%0d got %h expected %h", k, cp0_rdata, exp);
            end
        end
        checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0 || exl !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got flush=%b redirect=%h exl=%b expected 0,0,0",
                     flush, redirect_pc, exl);
        end
    endtask

    task automatic test_exception();
        idle();
        pc_valid = 1; pc_m = 32'h3008; exc_req = 5'b01010;
        #1;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== VEC) begin
            errors++;
            $display("FAIL exc_take got flush=%b redirect=%h expected 1 %h", flush, redirect_pc, VEC);
        end
        tick(); idle();
        cp0_addr = 5'd13; #1;
        checks++;
        if (cp0_rdata[6:2] !== 5'd10) begin
            errors++;
            $display("FAIL exc_code got %0d expected 10", cp0_rdata[6:2]);
        end
        cp0_addr = 5'd14; #1;
        checks++;
        if (cp0_rdata !== 32'h3008 || exl !== 1'b1) begin
            errors++;
            $display("FAIL exc_epc_exl got epc=%h exl=%b expected 3008 1", cp0_rdata, exl);
        end
        eret = 1; #1;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h3008) begin
            errors++;
            $display("FAIL eret_redirect got flush=%b redirect=%h expected 1 3008", flush, redirect_pc);
        end
        tick(); idle(); #1;
        checks++;
        if (exl !== 1'b0) begin
            errors++;
            $display("FAIL eret_exl got %b expected 0", exl);
        end
    endtask

    task automatic test_delay_slot();
        idle();
        pc_valid = 1; bd_m = 1; pc_m = 32'h3010; exc_req = 5'b01000;
        tick(); idle();
        cp0_addr = 5'd13; #1;
        checks++;
        if (cp0_rdata[6:2] !== 5'd5 || cp0_rdata[31] !== 1'b1) begin
            errors++;
            $display("FAIL bd_cause got code=%0d bd=%b expected 5 1", cp0_rdata[6:2], cp0_rdata[31]);
        end
        cp0_addr = 5'd14; #1;
        checks++;
        if (cp0_rdata !== 32'h300C) begin
            errors++;
            $display("FAIL bd_epc got %h expected 300c", cp0_rdata);
        end
        pc_valid = 1; exc_req = 5'b00001; pc_m = 32'h4000; #1;
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL nested_block got flush=%b expected 0", flush);
        end
        tick(); idle();
        cp0_addr = 5'd14; #1;
        checks++;
        if (cp0_rdata !== 32'h300C) begin
            errors++;
            $display("FAIL nested_epc got %h expected 300c", cp0_rdata);
        end
        eret = 1; tick(); idle();
    endtask

    task automatic test_interrupt();
        idle();
        cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
        tick(); idle();
        cp0_addr = 5'd12; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0401) begin
            errors++;
            $display("FAIL sr_write got %h expected 00000401", cp0_rdata);
        end
        hw_int = 6'b000001; pc_valid = 1; pc_m = 32'h3018; #1;
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL int_sample_delay got flush=%b expected 0", flush);
        end
        tick();
        pc_valid = 0; exc_req = 5'b00001; #1;
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL int_bubble got flush=%b expected 0", flush);
        end
        tick();
        pc_valid = 1; exc_req = 5'b00001; pc_m = 32'h3020; #1;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== VEC) begin
            errors++;
            $display("FAIL int_take got flush=%b redirect=%h expected 1 %h", flush, redirect_pc, VEC);
        end
        tick(); idle();
        cp0_addr = 5'd13; #1;
        checks++;
        if (cp0_rdata[6:2] !== 5'd0 || cp0_rdata[10] !== 1'b1) begin
            errors++;
            $display("FAIL int_cause got code=%0d ip0=%b expected 0 1", cp0_rdata[6:2], cp0_rdata[10]);
        end
        checks++;
        if (epc_out !== 32'h3020) begin
            errors++;
            $display("FAIL int_epc got %h expected 3020", epc_out);
        end
        hw_int = 0; eret = 1; tick(); idle();
    endtask

    task automatic test_eret_mtc0();
        idle();
        pc_valid = 1; pc_m = 32'h3040; exc_req = 5'b00100;
        tick(); idle();
        cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h3100; eret = 1; #1;
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h3040) begin
            errors++;
            $display("FAIL eret_old_epc got flush=%b redirect=%h expected 1 3040", flush, redirect_pc);
        end
        checks++;
        if (cp0_rdata !== 32'h3040) begin
            errors++;
            $display("FAIL read_no_bypass got %h expected 3040", cp0_rdata);
        end
        tick(); idle();
        cp0_addr = 5'd14; #1;
        checks++;
        if (exl !== 1'b0 || cp0_rdata !== 32'h3100 || epc_out !== 32'h3100) begin
            errors++;
            $display("FAIL eret_new_epc got exl=%b epc=%h/%h expected 0 3100", exl, cp0_rdata, epc_out);
        end
    endtask

    task automatic test_take_mtc0_reset();
        idle();
        pc_valid = 1; pc_m = 32'h3050; exc_req = 5'b00100;
        cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC00;
        tick(); idle();
        cp0_addr = 5'd12; #1;
        checks++;
        if (cp0_rdata !== 32'h0000_0403) begin
            errors++;
            $display("FAIL mtc0_in_take got %h expected 00000403", cp0_rdata);
        end
        reset = 1; tick(); reset = 0; #1;
        checks++;
        if (exl !== 1'b0 || epc_out !== 32'h0 || cp0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_handler got exl=%b epc=%h sr=%h expected 0 0 0", exl, epc_out, cp0_rdata);
        end
    endtask

    task automatic test_random();
        logic [4:0] addr_tab [6];
        addr_tab = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd12};
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            pc_valid  = ($urandom_range(0, 3) != 0);
            pc_m      = $urandom;
            bd_m      = 1'($urandom_range(0, 1));
            exc_req   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
            cp0_we    = ($urandom_range(0, 4) == 0);
            cp0_addr  = addr_tab[$urandom_range(0, 5)];
            cp0_wdata = $urandom;
            eret      = ($urandom_range(0, 4) == 0);
            #1;
            checks++;
            if (flush !== p_flush_exp() || redirect_pc !== p_redirect()) begin
                errors++;
                $display("FAIL rand_flush cyc %0d got %b/%h expected %b/%h",
                         n, flush, redirect_pc, p_flush_exp(), p_redirect());
            end
            checks++;
            if (cp0_rdata !== m_read(cp0_addr)) begin
                errors++;
                $display("FAIL rand_read cyc %0d addr %0d got %h expected %h",
                         n, cp0_addr, cp0_rdata, m_read(cp0_addr));
            end
            checks++;
            if (exl !== m_exl || epc_out !== m_epc) begin
                errors++;
                $display("FAIL rand_state cyc %0d got exl=%b epc=%h expected %b %h",
                         n, exl, epc_out, m_exl, m_epc);
            end
            tick();
        end
        reset = 0; idle();
    endtask

    function automatic logic p_flush_exp();
        return p_take() || eret;
    endfunction

    initial begin
        test_reset();
        test_exception();
        test_delay_slot();
        test_interrupt();
        test_eret_mtc0();
        test_take_mtc0_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
